// File: rtl/muldiv_sequencer.sv
// Iterative multiply/divide unit owning the HI/LO register pair.
// One shift-add (MULT/MULTU) or restoring shift-subtract (DIV/DIVU) step per
// cycle; signs are stripped in PREP and re-applied in FIX.
module muldiv_sequencer #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             mt_hi,
    input  logic             mt_lo,
    input  logic [WIDTH-1:0] mt_data,
    input  logic             hilo_read,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             stall_req
);

    localparam logic [5:0] F_MULT  = 6'h18;
    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_DIV   = 6'h1A;
    localparam logic [5:0] F_DIVU  = 6'h1B;

    typedef enum logic [2:0] {S_IDLE, S_PREP, S_RUN, S_FIX, S_DONE} state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 is_div_q, is_div_d;
    logic                 is_signed_q, is_signed_d;
    logic [WIDTH-1:0]     raw_a_q, raw_a_d;
    logic [WIDTH-1:0]     raw_b_q, raw_b_d;
    logic [WIDTH-1:0]     mcand_q, mcand_d;
    logic [WIDTH-1:0]     divisor_q, divisor_d;
    logic [WIDTH-1:0]     work_hi_q, work_hi_d;
    logic [WIDTH-1:0]     work_lo_q, work_lo_d;
    logic                 neg_res_q, neg_res_d;
    logic                 neg_rem_q, neg_rem_d;
    logic [WIDTH-1:0]     hi_q, hi_d;
    logic [WIDTH-1:0]     lo_q, lo_d;

    logic                 accept;
    logic [WIDTH:0]       rs;
    logic [WIDTH:0]       diff;
    logic [WIDTH:0]       sum;
    logic [2*WIDTH-1:0]   prod;

    // Two's-complement magnitude; the most negative value maps to itself,
    // which reads correctly as an unsigned magnitude.
    function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] v,
                                                 input logic sgn_op);
        return (sgn_op && v[WIDTH-1]) ? (~v + WIDTH'(1)) : v;
    endfunction

    function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v);
        return ~v + WIDTH'(1);
    endfunction

    function automatic logic valid_funct(input logic [5:0] f);
        return (f == F_MULT) || (f == F_MULTU) || (f == F_DIV) || (f == F_DIVU);
    endfunction

    assign busy      = (state_q == S_PREP) || (state_q == S_RUN) || (state_q == S_FIX);
    assign done      = (state_q == S_DONE);
    assign stall_req = busy & (start | hilo_read | mt_hi | mt_lo);
    assign hi        = hi_q;
    assign lo        = lo_q;
    assign accept    = start && valid_funct(funct) &&
                       ((state_q == S_IDLE) || (state_q == S_DONE));

    // Next-state, datapath step and HI/LO update logic
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        is_div_d    = is_div_q;
        is_signed_d = is_signed_q;
        raw_a_d     = raw_a_q;
        raw_b_d     = raw_b_q;
        mcand_d     = mcand_q;
        divisor_d   = divisor_q;
        work_hi_d   = work_hi_q;
        work_lo_d   = work_lo_q;
        neg_res_d   = neg_res_q;
        neg_rem_d   = neg_rem_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        rs          = '0;
        diff        = '0;
        sum         = '0;
        prod        = '0;

        case (state_q)
            S_IDLE, S_DONE: begin
                // MT writes land even when a start is accepted the same cycle;
                // the operation's result overwrites them later.
                if (mt_hi) hi_d = mt_data;
                if (mt_lo) lo_d = mt_data;
                if (accept) begin
                    state_d     = S_PREP;
                    is_div_d    = funct[1];
                    is_signed_d = ~funct[0];
                    raw_a_d     = op_a;
                    raw_b_d     = op_b;
                end else if (state_q == S_DONE) begin
                    state_d = S_IDLE;
                end
            end
            S_PREP: begin
                mcand_d   = abs_val(raw_a_q, is_signed_q);
                divisor_d = abs_val(raw_b_q, is_signed_q);
                work_hi_d = '0;
                work_lo_d = is_div_q ? abs_val(raw_a_q, is_signed_q)
                                     : abs_val(raw_b_q, is_signed_q);
                neg_res_d = is_signed_q & (raw_a_q[WIDTH-1] ^ raw_b_q[WIDTH-1]);
                neg_rem_d = is_signed_q & raw_a_q[WIDTH-1];
                cnt_d     = CNT_W'(WIDTH);
                state_d   = S_RUN;
            end
            S_RUN: begin
                if (is_div_q) begin
                    // Restoring division: shift in next dividend bit, subtract if it fits.
                    rs   = {work_hi_q, work_lo_q[WIDTH-1]};
                    diff = rs - {1'b0, divisor_q};
                    if (rs >= {1'b0, divisor_q}) begin
                        work_hi_d = diff[WIDTH-1:0];
                        work_lo_d = {work_lo_q[WIDTH-2:0], 1'b1};
                    end else begin
                        work_hi_d = rs[WIDTH-1:0];
                        work_lo_d = {work_lo_q[WIDTH-2:0], 1'b0};
                    end
                end else begin
                    // Shift-add: multiplier sits in the low half and drains out LSB first.
                    sum       = {1'b0, work_hi_q} +
                                (work_lo_q[0] ? {1'b0, mcand_q} : '0);
                    work_hi_d = sum[WIDTH:1];
                    work_lo_d = {sum[0], work_lo_q[WIDTH-1:1]};
                end
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) state_d = S_FIX;
            end
            S_FIX: begin
                if (is_div_q) begin
                    if (raw_b_q == '0) begin
                        lo_d = '1;
                        hi_d = raw_a_q;
                    end else begin
                        lo_d = neg_res_q ? neg_w(work_lo_q) : work_lo_q;
                        hi_d = neg_rem_q ? neg_w(work_hi_q) : work_hi_q;
                    end
                end else begin
                    prod = {work_hi_q, work_lo_q};
                    if (neg_res_q) prod = ~prod + (2*WIDTH)'(1);
                    hi_d = prod[2*WIDTH-1:WIDTH];
                    lo_d = prod[WIDTH-1:0];
                end
                state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State, working registers and HI/LO; async reset aborts any operation
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            is_div_q    <= 1'b0;
            is_signed_q <= 1'b0;
            raw_a_q     <= '0;
            raw_b_q     <= '0;
            mcand_q     <= '0;
            divisor_q   <= '0;
            work_hi_q   <= '0;
            work_lo_q   <= '0;
            neg_res_q   <= 1'b0;
            neg_rem_q   <= 1'b0;
            hi_q        <= '0;
            lo_q        <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            is_div_q    <= is_div_d;
            is_signed_q <= is_signed_d;
            raw_a_q     <= raw_a_d;
            raw_b_q     <= raw_b_d;
            mcand_q     <= mcand_d;
            divisor_q   <= divisor_d;
            work_hi_q   <= work_hi_d;
            work_lo_q   <= work_lo_d;
            neg_res_q   <= neg_res_d;
            neg_rem_q   <= neg_rem_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
        end
    end

endmodule
